execute_alu_unit: RTL and testbench

- Execute-stage arithmetic block of the pipelined MIPS core: merges ALU control decode and the ALU datapath.
- Decodes the 2-bit ALUOp from main control plus the R-type funct field into a 4-bit ALU control code.
- Applies that operation to two operands and registers the result, zero flag and control code into the stage output register.
- Latency is one clock.

---
 rtl/execute_alu_unit.sv | 102 ++++++++++
 tb/tb_execute_alu_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/execute_alu_unit.sv
// Execute-stage ALU for the pipelined MIPS core: decodes ALUOp/funct into an
// ALU control code, computes the result and registers result, zero and code.
module execute_alu_unit #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALUCTL = 4,
    parameter int NB_OP     = 2,
    parameter int NB_FUNC   = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_valid,
    input  logic [NB_OP-1:0]     i_ALUOp,
    input  logic [NB_FUNC-1:0]   i_funct,
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    output logic [NB_ALUCTL-1:0] o_ALUctl,
    output logic [NB_DATA-1:0]   o_ALUOut,
    output logic                 o_zero,
    output logic                 o_valid
);

    localparam logic [NB_ALUCTL-1:0] CTL_AND  = 4'b0000;
    localparam logic [NB_ALUCTL-1:0] CTL_OR   = 4'b0001;
    localparam logic [NB_ALUCTL-1:0] CTL_ADD  = 4'b0010;
    localparam logic [NB_ALUCTL-1:0] CTL_XOR  = 4'b0011;
    localparam logic [NB_ALUCTL-1:0] CTL_SUB  = 4'b0110;
    localparam logic [NB_ALUCTL-1:0] CTL_SLT  = 4'b0111;
    localparam logic [NB_ALUCTL-1:0] CTL_NOR  = 4'b1100;
    localparam logic [NB_ALUCTL-1:0] CTL_SLTU = 4'b1111;

    logic [NB_ALUCTL-1:0] alu_ctl_s;
    logic [NB_DATA-1:0]   result_s;
    logic                 zero_s;
    logic                 slt_s;
    logic                 sltu_s;
    logic                 unused_funct_s;

    // Only funct[3:0] selects the R-type operation; the upper bits are don't-care.
    assign unused_funct_s = ^i_funct[NB_FUNC-1:4];

    // ALU control decode from ALUOp and the R-type funct field.
    always_comb begin
        alu_ctl_s = CTL_ADD;
        case (i_ALUOp)
            2'b00: alu_ctl_s = CTL_ADD;
            2'b01: alu_ctl_s = CTL_SUB;
            2'b11: alu_ctl_s = CTL_OR;
            2'b10: begin
                case (i_funct[3:0])
                    4'b0000, 4'b0001: alu_ctl_s = CTL_ADD;
                    4'b0010, 4'b0011: alu_ctl_s = CTL_SUB;
                    4'b0100:          alu_ctl_s = CTL_AND;
                    4'b0101:          alu_ctl_s = CTL_OR;
                    4'b0110:          alu_ctl_s = CTL_XOR;
                    4'b0111:          alu_ctl_s = CTL_NOR;
                    4'b1010:          alu_ctl_s = CTL_SLT;
                    4'b1011:          alu_ctl_s = CTL_SLTU;
                    default:          alu_ctl_s = CTL_ADD;
                endcase
            end
            default: alu_ctl_s = CTL_ADD;
        endcase
    end

    assign slt_s  = ($signed(i_data_a) < $signed(i_data_b));
    assign sltu_s = (i_data_a < i_data_b);

    // Datapath: ADD/SUB wrap silently, set-less-than results are zero-extended.
    always_comb begin
        result_s = {NB_DATA{1'b0}};
        case (alu_ctl_s)
            CTL_AND:  result_s = i_data_a & i_data_b;
            CTL_OR:   result_s = i_data_a | i_data_b;
            CTL_ADD:  result_s = i_data_a + i_data_b;
            CTL_XOR:  result_s = i_data_a ^ i_data_b;
            CTL_SUB:  result_s = i_data_a - i_data_b;
            CTL_SLT:  result_s = {{(NB_DATA-1){1'b0}}, slt_s};
            CTL_NOR:  result_s = ~(i_data_a | i_data_b);
            CTL_SLTU: result_s = {{(NB_DATA-1){1'b0}}, sltu_s};
            default:  result_s = {NB_DATA{1'b0}};
        endcase
    end

    assign zero_s = (result_s == {NB_DATA{1'b0}});

    // Stage output register: reset beats stall, stall holds every output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ALUctl <= {NB_ALUCTL{1'b0}};
            o_ALUOut <= {NB_DATA{1'b0}};
            o_zero   <= 1'b0;
            o_valid  <= 1'b0;
        end else if (!i_stall) begin
            o_ALUctl <= alu_ctl_s;
            o_ALUOut <= result_s;
            o_zero   <= zero_s;
            o_valid  <= i_valid;
        end
    end

endmodule

// File: tb/tb_execute_alu_unit.sv
// Randomized self-checking bench for execute_alu_unit at a 10-bit datapath,
// compared against an arithmetic reference model of the ALU stage.
module tb_execute_alu_unit;

    localparam int W   = 10;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n, stall, valid;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] data_a, data_b;
    logic [3:0]   alu_ctl;
    logic [W-1:0] alu_out;
    logic         zero, out_valid;

    int checks   = 0;
    int failures = 0;

    int exp_ctl   = 0;
    int exp_out   = 0;
    int exp_zero  = 0;
    int exp_valid = 0;

    always #5 clk = ~clk;

    execute_alu_unit #(.NB_DATA(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_stall  (stall),
        .i_valid  (valid),
        .i_ALUOp  (alu_op),
        .i_funct  (funct),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .o_ALUctl (alu_ctl),
        .o_ALUOut (alu_out),
        .o_zero   (zero),
        .o_valid  (out_valid)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Operation class chosen by ALUOp / funct, expressed as the control code.
    function automatic int model_ctl(input int op, input int fn);
        int low;
        low = fn % 16;
        if (op == 0) return 2;
        if (op == 1) return 6;
        if (op == 3) return 1;
        if (low == 0 || low == 1) return 2;
        if (low == 2 || low == 3) return 6;
        if (low == 4) return 0;
        if (low == 5) return 1;
        if (low == 6) return 3;
        if (low == 7) return 12;
        if (low == 10) return 7;
        if (low == 11) return 15;
        return 2;
    endfunction

    function automatic int model_res(input int ctl, input int a, input int b);
        int sa, sb;
        sa = (a >= MOD / 2) ? a - MOD : a;
        sb = (b >= MOD / 2) ? b - MOD : b;
        case (ctl)
            0:       return a & b;
            1:       return a | b;
            2:       return (a + b) % MOD;
            3:       return a ^ b;
            6:       return (a - b + MOD) % MOD;
            7:       return (sa < sb) ? 1 : 0;
            12:      return (MOD - 1) - (a | b);
            15:      return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic cycle(input int r, input int s, input int v, input int op,
                         input int fn, input int a, input int b);
        rst_n  = 1'(r);
        stall  = 1'(s);
        valid  = 1'(v);
        alu_op = 2'(op);
        funct  = 6'(fn);
        data_a = W'(a);
        data_b = W'(b);
        @(posedge clk);
        #1;
        if (r == 0) begin
            exp_ctl = 0; exp_out = 0; exp_zero = 0; exp_valid = 0;
        end else if (s == 0) begin
            exp_ctl   = model_ctl(op, fn);
            exp_out   = model_res(exp_ctl, a, b);
            exp_zero  = (exp_out == 0) ? 1 : 0;
            exp_valid = v;
        end
        check("ctl",   int'(alu_ctl),   exp_ctl);
        check("out",   int'(alu_out),   exp_out);
        check("zero",  int'(zero),      exp_zero);
        check("valid", int'(out_valid), exp_valid);
    endtask

    initial begin
        int a, b;

        // Reset with non-zero operands on the bus
        cycle(0, 0, 1, 0, 'h00, 'h155, 'h0AA);
        check("rst_out", int'(alu_out), 0);

        cycle(1, 0, 1, 0, 'h00, 5, 3);
        check("add_out", int'(alu_out), 'h008);
        check("add_ctl", int'(alu_ctl), 'b0010);

        cycle(1, 0, 1, 1, 'h00, 'h155, 'h155);
        check("beq_zero", int'(zero), 1);
        check("beq_ctl", int'(alu_ctl), 'b0110);

        cycle(1, 0, 1, 2, 'h22, 3, 5); check("sub_out", int'(alu_out), 'h3FE);
        cycle(1, 0, 1, 2, 'h24, 3, 5); check("and_out", int'(alu_out), 'h001);
        cycle(1, 0, 1, 2, 'h25, 3, 5); check("or_out",  int'(alu_out), 'h007);
        cycle(1, 0, 1, 2, 'h26, 3, 5); check("xor_out", int'(alu_out), 'h006);
        cycle(1, 0, 1, 2, 'h27, 3, 5); check("nor_out", int'(alu_out), 'h3F8);
        cycle(1, 0, 1, 2, 'h0F, 3, 5); check("undef_out", int'(alu_out), 'h008);

        cycle(1, 0, 1, 2, 'h2A, 'h3FF, 1); check("slt_out", int'(alu_out), 1);
        cycle(1, 0, 1, 2, 'h2B, 'h3FF, 1);
        check("sltu_out", int'(alu_out), 0);
        check("sltu_zero", int'(zero), 1);

        cycle(1, 0, 1, 3, 'h00, 'h0F0, 'h00F); check("ori_out", int'(alu_out), 'h0FF);

        // Stall holds the ADD result while inputs move
        cycle(1, 0, 1, 0, 'h00, 5, 3);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 1, 'h00, 100 + i, 7);
            check("stall_out", int'(alu_out), 8);
            check("stall_ctl", int'(alu_ctl), 'b0010);
        end
        cycle(1, 0, 1, 1, 'h00, 100, 7); check("unstall_out", int'(alu_out), 93);

        // Reset mid-stream, even while stalled
        cycle(0, 1, 1, 0, 'h00, 1, 1); check("rst_stall_out", int'(alu_out), 0);

        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(MOD - 1, 0));
            b = ($urandom_range(7, 0) == 0) ? a : int'($urandom_range(MOD - 1, 0));
            cycle(($urandom_range(19, 0) == 0) ? 0 : 1,
                  ($urandom_range(4, 0) == 0) ? 1 : 0,
                  int'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)),
                  int'($urandom_range(63, 0)),
                  a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
